// File: rtl/axi_mem_responder_if.sv
// axi_interface: AXI4 bundle between a master and a slave.
// The slave modport is what axi_mem_responder terminates.
interface axi_interface #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    // Write address channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backed by a word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs, one burst each in flight.
// Every burst is INCR at full bus width; the word index wraps around the RAM.
module axi_mem_responder #(
    parameter int ID_WIDTH       = 1,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input logic         ap_clk,
    input logic         ap_rst,
    axi_interface.slave to_master
);
    localparam int LS         = $clog2(DATA_WIDTH / 8);
    localparam int MEM_WORDS  = 1 << MEM_WORDS_LOG2;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [MEM_WORDS_LOG2-1:0] idx_t;
    typedef logic [ID_WIDTH-1:0]       id_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // NOTE: the RAM has no reset; clearing thousands of words on reset is not
    // something real memory does, and a burst abandoned by reset keeps its bytes.
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // Write channel state
    w_state_e  w_state_q, w_state_d;
    idx_t      w_idx_q,   w_idx_d;
    logic [7:0] w_len_q,  w_len_d;
    logic [7:0] w_cnt_q,  w_cnt_d;
    logic      w_err_q,   w_err_d;
    id_t       w_id_q,    w_id_d;
    logic      awready_q, awready_d;
    logic      wready_q,  wready_d;
    logic      bvalid_q,  bvalid_d;
    logic      w_last_beat;
    logic      mem_we;

    // Read channel state
    r_state_e  r_state_q, r_state_d;
    idx_t      r_idx_q,   r_idx_d;
    logic [7:0] r_len_q,  r_len_d;
    logic [7:0] r_cnt_q,  r_cnt_d;
    id_t       r_id_q,    r_id_d;
    logic      arready_q, arready_d;
    logic      rvalid_q,  rvalid_d;
    logic      rlast_q,   rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    idx_t      ar_start;
    idx_t      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign w_last_beat = (w_cnt_q == w_len_q);
    assign ar_start    = to_master.araddr[LS +: MEM_WORDS_LOG2];

    // Single read port: the burst start while idle, otherwise the next word.
    assign rd_idx  = (r_state_q == R_IDLE) ? ar_start : r_idx_q + idx_t'(1);
    assign rd_word = mem_q[rd_idx];

    // Write FSM next state: address capture, beat writes, protocol check, response.
    // NOTE: every variable gets its default before the case so no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_id_d    = w_id_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (to_master.awvalid) begin
                    w_idx_d   = to_master.awaddr[LS +: MEM_WORDS_LOG2];
                    w_len_d   = to_master.awlen;
                    w_id_d    = to_master.awid;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (to_master.wvalid) begin
                    mem_we = 1'b1;
                    // WLAST must coincide exactly with beat AWLEN.
                    if (to_master.wlast != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    // The burst length comes from AWLEN, not from WLAST.
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_idx_d = w_idx_q + idx_t'(1);
                    end
                end
            end
            W_RESP: begin
                if (to_master.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM registers; handshake outputs are registered from the next state.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            w_id_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_id_q    <= w_id_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // RAM write port: byte-lane writes under WSTRB, suppressed during reset.
    always_ff @(posedge ap_clk) begin
        if (mem_we && !ap_rst) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (to_master.wstrb[b]) begin
                    mem_q[w_idx_q][b*8 +: 8] <= to_master.wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next state: capture AR, preload beat 0, advance on each R handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_id_d    = r_id_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (to_master.arvalid) begin
                    r_idx_d   = ar_start;
                    r_len_d   = to_master.arlen;
                    r_id_d    = to_master.arid;
                    r_cnt_d   = 8'd0;
                    rdata_d   = rd_word;
                    rlast_d   = (to_master.arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (to_master.rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = rd_idx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = rd_word;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Read FSM registers; RDATA/RLAST only move on a handshake so they hold during stalls.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_id_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_id_q    <= r_id_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    assign to_master.awready = awready_q;
    assign to_master.wready  = wready_q;
    assign to_master.bvalid  = bvalid_q;
    assign to_master.bid     = w_id_q;
    assign to_master.bresp   = w_err_q ? 2'b10 : 2'b00;
    assign to_master.arready = arready_q;
    assign to_master.rvalid  = rvalid_q;
    assign to_master.rlast   = rlast_q;
    assign to_master.rid     = r_id_q;
    assign to_master.rdata   = rdata_q;
    assign to_master.rresp   = 2'b00;

    // Attributes this responder deliberately ignores, plus the address bits outside the index.
    logic unused_ok;
    assign unused_ok = ^{to_master.awaddr, to_master.awsize, to_master.awburst, to_master.awlock,
                         to_master.awcache, to_master.awprot, to_master.awqos, to_master.awregion,
                         to_master.araddr, to_master.arsize, to_master.arburst, to_master.arlock,
                         to_master.arcache, to_master.arprot, to_master.arqos, to_master.arregion,
                         r_cnt_q};
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed checks of axi_mem_responder with hand-computed expectations.
module tb_axi_mem_responder;
    logic ap_clk = 1'b0;
    logic ap_rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [63:0] wd [0:15];
    logic [7:0]  ws [0:15];
    logic [63:0] rd [0:15];
    logic        rl [0:15];

    axi_interface #(.ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_mem_responder #(
        .ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_WORDS_LOG2(10)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .to_master(bus)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full write burst: AW, beats from wd/ws (WLAST on beat last_at), then B.
    task automatic do_write(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int last_at, output logic [1:0] resp, output int aw_cyc);
        int g;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
        g = 0;
        while (!bus.awready && g < 50) begin tick(); g++; end
        check("aw_ready_wait", 64'(bus.awready), 64'd1);
        tick();
        aw_cyc = cyc;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
            g = 0;
            while (!bus.wready && g < 50) begin tick(); g++; end
            if (g == 50) check("w_ready_wait", 64'(bus.wready), 64'd1);
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        g = 0;
        while (!bus.bvalid && g < 50) begin tick(); g++; end
        check("b_valid_wait", 64'(bus.bvalid), 64'd1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    // Full read burst into rd/rl; RREADY follows pattern bit (cycle % 4); stalls must hold data.
    task automatic do_read(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [3:0] pattern, output int ar_cyc);
        int g, beat, c;
        logic stalled;
        logic [63:0] hold_d;
        logic hold_l;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
        g = 0;
        while (!bus.arready && g < 50) begin tick(); g++; end
        check("ar_ready_wait", 64'(bus.arready), 64'd1);
        tick();
        ar_cyc = cyc;
        bus.arvalid = 1'b0;
        beat = 0; c = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        while (beat <= int'(len) && c < 200) begin
            if (stalled) begin
                check("r_hold_data", bus.rdata, hold_d);
                check("r_hold_last", 64'(bus.rlast), 64'(hold_l));
            end
            bus.rready = pattern[c % 4];
            stalled = bus.rvalid && !bus.rready;
            hold_d = bus.rdata; hold_l = bus.rlast;
            if (bus.rvalid && bus.rready) begin
                rd[beat] = bus.rdata; rl[beat] = bus.rlast; beat++;
            end
            tick();
            c++;
        end
        bus.rready = 1'b0;
        check("r_beats_done", 64'(beat), 64'(int'(len) + 1));
    endtask

    initial begin
        logic [1:0] resp, resp2;
        int t0, aw_t, ar_t;

        ap_rst = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_awready", 64'(bus.awready), 64'd0);
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_wready",  64'(bus.wready),  64'd0);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_rlast",   64'(bus.rlast),   64'd0);
        check("rst_rdata",   bus.rdata,        64'd0);
        check("rst_bresp",   64'(bus.bresp),   64'd0);
        ap_rst = 1'b0;
        tick();
        check("post_rst_awready", 64'(bus.awready), 64'd1);
        check("post_rst_arready", 64'(bus.arready), 64'd1);

        // Single write at 0x40 with exact cycle timing
        bus.awid = 1'b1; bus.awaddr = 64'h40; bus.awlen = 8'd0; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("t1_wready_after_aw", 64'(bus.wready), 64'd1);
        check("t1_awready_low",     64'(bus.awready), 64'd0);
        bus.wvalid = 1'b1; bus.wdata = 64'h1122334455667788; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("t1_wready_drop", 64'(bus.wready), 64'd0);
        check("t1_bvalid",      64'(bus.bvalid), 64'd1);
        check("t1_bresp",       64'(bus.bresp),  64'd0);
        check("t1_bid",         64'(bus.bid),    64'd1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("t1_bvalid_clear",  64'(bus.bvalid),  64'd0);
        check("t1_awready_again", 64'(bus.awready), 64'd1);
        bus.arid = 1'b1; bus.araddr = 64'h40; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("t1_rvalid",      64'(bus.rvalid),  64'd1);
        check("t1_rdata",       bus.rdata,        64'h1122334455667788);
        check("t1_rlast",       64'(bus.rlast),   64'd1);
        check("t1_rid",         64'(bus.rid),     64'd1);
        check("t1_rresp",       64'(bus.rresp),   64'd0);
        check("t1_arready_low", 64'(bus.arready), 64'd0);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("t1_rvalid_clear",  64'(bus.rvalid),  64'd0);
        check("t1_arready_again", 64'(bus.arready), 64'd1);

        // Burst with partial strobe on beat 2, read back with RREADY toggling
        wd[0] = 64'hAAAABBBBCCCCDDDD; ws[0] = 8'hFF;
        do_write(1'b0, 64'h110, 8'd0, 0, resp, aw_t);
        check("t2_pre_bresp", 64'(resp), 64'd0);
        wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3; wd[3] = 64'd4;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'h0F; ws[3] = 8'hFF;
        do_write(1'b1, 64'h100, 8'd3, 3, resp, aw_t);
        check("t2_bresp", 64'(resp), 64'd0);
        do_read(1'b0, 64'h100, 8'd3, 4'b0101, ar_t);
        check("t2_beat0", rd[0], 64'd1);
        check("t2_beat1", rd[1], 64'd2);
        check("t2_beat2", rd[2], 64'hAAAABBBB00000003);
        check("t2_beat3", rd[3], 64'd4);
        check("t2_last0", 64'(rl[0]), 64'd0);
        check("t2_last1", 64'(rl[1]), 64'd0);
        check("t2_last2", 64'(rl[2]), 64'd0);
        check("t2_last3", 64'(rl[3]), 64'd1);

        // Early WLAST: error response, all three beats still written
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
        do_write(1'b0, 64'h200, 8'd2, 1, resp, aw_t);
        check("t3_bresp_slverr", 64'(resp), 64'd2);
        do_read(1'b0, 64'h200, 8'd2, 4'b1111, ar_t);
        check("t3_beat0", rd[0], 64'h11);
        check("t3_beat2", rd[2], 64'h33);

        // Index wrap from word 1023 to word 0, and upper address aliasing
        wd[0] = 64'hA0A0; wd[1] = 64'hB0B0; ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(1'b0, 64'h1FF8, 8'd1, 1, resp, aw_t);
        check("t4_bresp", 64'(resp), 64'd0);
        do_read(1'b0, 64'h0, 8'd0, 4'b1111, ar_t);
        check("t4_word0", rd[0], 64'hB0B0);
        do_read(1'b0, 64'h1FF8, 8'd1, 4'b1111, ar_t);
        check("t4_wrap_beat0", rd[0], 64'hA0A0);
        check("t4_wrap_beat1", rd[1], 64'hB0B0);
        wd[0] = 64'hC0C0;
        do_write(1'b0, 64'h1_0000_0040, 8'd0, 0, resp, aw_t);
        do_read(1'b0, 64'h40, 8'd0, 4'b1111, ar_t);
        check("t4_alias", rd[0], 64'hC0C0);

        // Concurrent AW and AR bursts to disjoint regions
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h5000 + 64'(i); ws[i] = 8'hFF; end
        do_write(1'b0, 64'h800, 8'd7, 7, resp, aw_t);
        for (int i = 0; i < 8; i++) wd[i] = 64'h6000 + 64'(i);
        t0 = cyc;
        fork
            do_write(1'b1, 64'hC00, 8'd7, 7, resp2, aw_t);
            do_read(1'b1, 64'h800, 8'd7, 4'b1111, ar_t);
        join
        check("t5_aw_within_10", 64'(aw_t - t0 <= 10), 64'd1);
        check("t5_ar_within_10", 64'(ar_t - t0 <= 10), 64'd1);
        check("t5_same_cycle",   64'(aw_t == ar_t),    64'd1);
        check("t5_bresp",        64'(resp2),           64'd0);
        check("t5_rd_beat0",     rd[0],                64'h5000);
        check("t5_rd_beat7",     rd[7],                64'h5007);
        check("t5_rd_last7",     64'(rl[7]),           64'd1);
        do_read(1'b0, 64'hC00, 8'd7, 4'b1111, ar_t);
        check("t5_wr_beat0", rd[0], 64'h6000);
        check("t5_wr_beat7", rd[7], 64'h6007);

        // Same-cycle write and read of one word returns the old contents
        bus.awid = 1'b0; bus.awaddr = 64'h40; bus.awlen = 8'd0; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 64'hD0D0; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        bus.arid = 1'b0; bus.araddr = 64'h40; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        check("t5_rw_rvalid",   64'(bus.rvalid), 64'd1);
        check("t5_rw_old_data", bus.rdata,       64'hC0C0);
        check("t5_rw_bvalid",   64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(1'b0, 64'h40, 8'd0, 4'b1111, ar_t);
        check("t5_rw_new_data", rd[0], 64'hD0D0);

        // Reset during beat 2 of an 8-beat read
        bus.arid = 1'b0; bus.araddr = 64'h800; bus.arlen = 8'd7; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        check("t6_beat0", bus.rdata, 64'h5000);
        tick();
        check("t6_beat1", bus.rdata, 64'h5001);
        tick();
        check("t6_beat2", bus.rdata, 64'h5002);
        ap_rst = 1'b1; bus.rready = 1'b0;
        tick();
        check("t6_rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("t6_rst_arready", 64'(bus.arready), 64'd0);
        check("t6_rst_rdata",   bus.rdata,        64'd0);
        ap_rst = 1'b0;
        tick();
        check("t6_arready_after", 64'(bus.arready), 64'd1);
        check("t6_rvalid_after",  64'(bus.rvalid),  64'd0);
        do_read(1'b0, 64'h800, 8'd1, 4'b1111, ar_t);
        check("t6_new_beat0", rd[0],      64'h5000);
        check("t6_new_beat1", rd[1],      64'h5001);
        check("t6_new_last1", 64'(rl[1]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
